// File: rtl/bram_scan_ctrl.sv
// Scan/write bus master for a dual-port block RAM with a one-cycle registered read.
// Sweeps every address on go and services single-word writes, deferring any that hit the word being read.
module bram_scan_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 2,
  parameter int SCAN_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_r_addr,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] READ    = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] GAP     = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((SCAN_GAP > 0) ? SCAN_GAP - 1 : 0);

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [GAP_W-1:0]  gap_cnt;
  logic [GAP_W-1:0]  next_gap;
  logic              coll;
  logic              wr_fire;

  always_comb begin
    next_state = state;
    next_addr  = scan_addr;
    next_gap   = gap_cnt;
    case (state)
      IDLE: begin
        if (go) begin
          next_state = READ;
          next_addr  = '0;
        end
      end
      READ: next_state = CAPTURE;
      CAPTURE: begin
        if (scan_addr == '1) begin
          next_state = DONE;
        end else if (SCAN_GAP > 0) begin
          next_state = GAP;
          next_gap   = '0;
        end else begin
          next_state = READ;
          next_addr  = scan_addr + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          next_state = READ;
          next_addr  = scan_addr + 1'b1;
        end else begin
          next_gap = gap_cnt + 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
        next_addr  = '0;
      end
      default: begin
        next_state = IDLE;
        next_addr  = '0;
      end
    endcase
  end

  // A write landing on the word being read next cycle waits one cycle,
  // so the scan sees the old value; wr_ack stays low and it retries.
  assign coll    = (next_state == READ) && (next_addr == wr_addr);
  assign wr_fire = wr_req && !wr_ack && !coll;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      scan_addr  <= '0;
      gap_cnt    <= '0;
      ram_r_en   <= 1'b0;
      ram_r_addr <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      scan_addr  <= next_addr;
      gap_cnt    <= next_gap;
      ram_r_en   <= (next_state == READ);
      ram_r_addr <= next_addr;
      out_valid  <= (state == CAPTURE);
      done       <= (state == CAPTURE) && (scan_addr == '1);
      busy       <= (next_state != IDLE);
      if (state == CAPTURE) begin
        out_addr <= scan_addr;
        out_data <= ram_r_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack     <= 1'b0;
      ram_w_en   <= 1'b0;
      ram_w_addr <= '0;
      ram_w_data <= '0;
    end else begin
      wr_ack   <= wr_fire;
      ram_w_en <= wr_fire;
      if (wr_fire) begin
        ram_w_addr <= wr_addr;
        ram_w_data <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_bram_scan_ctrl.sv
// Directed bench for bram_scan_ctrl: two instances (gap 1 and gap 0), each
// driving its own behavioural dual-port RAM preloaded with addr mod 4.
module tb_bram_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       init;
  logic       go, go0;
  logic       wr_req;
  logic [3:0] wr_addr;
  logic [1:0] wr_data;

  logic       wr_ack, ram_w_en, ram_r_en, out_valid, busy, done;
  logic [3:0] ram_w_addr, ram_r_addr, out_addr;
  logic [1:0] ram_w_data, ram_r_data, out_data;

  logic       wr_ack0, ram_w_en0, ram_r_en0, out_valid0, busy0, done0;
  logic [3:0] ram_w_addr0, ram_r_addr0, out_addr0;
  logic [1:0] ram_w_data0, ram_r_data0, out_data0;

  logic [1:0] mem [16];
  logic [1:0] mem0 [16];
  logic [1:0] exp_mem [16];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bram_scan_ctrl #(.ADDR_W(4), .DATA_W(2), .SCAN_GAP(1)) dut (
    .clk(clk), .rst(rst), .go(go),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .ram_w_en(ram_w_en),
    .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr),
    .ram_r_data(ram_r_data),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  bram_scan_ctrl #(.ADDR_W(4), .DATA_W(2), .SCAN_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .go(go0),
    .wr_req(1'b0), .wr_addr(4'd0), .wr_data(2'd0),
    .wr_ack(wr_ack0), .ram_w_en(ram_w_en0),
    .ram_w_addr(ram_w_addr0), .ram_w_data(ram_w_data0),
    .ram_r_en(ram_r_en0), .ram_r_addr(ram_r_addr0),
    .ram_r_data(ram_r_data0),
    .out_valid(out_valid0), .out_addr(out_addr0), .out_data(out_data0),
    .busy(busy0), .done(done0)
  );

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 16; i++) begin
        mem[i]  <= 2'(i);
        mem0[i] <= 2'(i);
      end
    end else begin
      if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
      if (ram_r_en) ram_r_data <= mem[ram_r_addr];
      if (ram_w_en0) mem0[ram_w_addr0] <= ram_w_data0;
      if (ram_r_en0) ram_r_data0 <= mem0[ram_r_addr0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full scan on the gap-1 instance; coll >= 0 injects a write of 3 that
  // is timed to collide with the READ of address coll.
  task automatic run_scan(input int coll);
    logic [1:0] snap [16];
    bit ev;
    for (int i = 0; i < 16; i++) snap[i] = exp_mem[i];
    @(negedge clk);
    go = 1'b1;
    for (int c = 0; c <= 48; c++) begin
      @(negedge clk);
      if (c == 0) go = 1'b0;
      if (coll >= 0 && c == 3 * coll - 1) begin
        wr_req  = 1'b1;
        wr_addr = 4'(coll);
        wr_data = 2'd3;
      end
      if (coll >= 0 && c == 3 * coll) begin
        chk("coll_r_en", 32'(ram_r_en), 32'd1);
        chk("coll_r_addr", 32'(ram_r_addr), 32'(coll));
        chk("coll_ack_deferred", 32'(wr_ack), 32'd0);
      end
      if (coll >= 0 && c == 3 * coll + 1) begin
        chk("coll_w_en", 32'(ram_w_en), 32'd1);
        chk("coll_ack", 32'(wr_ack), 32'd1);
        chk("coll_w_addr", 32'(ram_w_addr), 32'(coll));
        chk("coll_w_data", 32'(ram_w_data), 32'd3);
        wr_req = 1'b0;
        exp_mem[coll] = 2'd3;
      end
      ev = (c >= 2) && ((c - 2) % 3 == 0);
      chk("scan_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        chk("scan_addr", 32'(out_addr), 32'((c - 2) / 3));
        chk("scan_data", 32'(out_data), 32'(snap[(c - 2) / 3]));
      end
      chk("scan_done", 32'(done), 32'(c == 47));
      if (c == 0) chk("scan_busy_rise", 32'(busy), 32'd1);
      if (c == 48) chk("scan_busy_fall", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int strobes;
    bit ev;
    rst = 1'b1; init = 1'b1; go = 1'b0; go0 = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 2'(i);
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack", 32'(wr_ack), 32'd0);
    chk("rst_r_en", 32'(ram_r_en), 32'd0);
    chk("rst_w_en", 32'(ram_w_en), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0; init = 1'b0;
    @(negedge clk);

    run_scan(-1);

    wr_req = 1'b1; wr_addr = 4'd12; wr_data = 2'b01;
    @(negedge clk);
    chk("wr_ack", 32'(wr_ack), 32'd1);
    chk("wr_w_en", 32'(ram_w_en), 32'd1);
    chk("wr_w_addr", 32'(ram_w_addr), 32'd12);
    chk("wr_w_data", 32'(ram_w_data), 32'd1);
    wr_req = 1'b0;
    @(negedge clk);
    chk("wr_ack_pulse", 32'(wr_ack), 32'd0);
    exp_mem[12] = 2'b01;
    run_scan(-1);

    run_scan(5);
    run_scan(-1);

    wr_req = 1'b1; wr_addr = 4'd3; wr_data = 2'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("held_ack", 32'(wr_ack), 32'(i % 2 == 0));
      chk("held_w_en", 32'(ram_w_en), 32'(i % 2 == 0));
    end
    wr_req = 1'b0;
    exp_mem[3] = 2'd2;
    @(negedge clk);
    chk("held_ack_end", 32'(wr_ack), 32'd0);

    go = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (c == 0) go = 1'b0;
    end
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_addr", 32'(out_addr), 32'd6);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_r_en", 32'(ram_r_en), 32'd0);
    chk("mid_rst_addr", 32'(out_addr), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    run_scan(-1);

    strobes = 0;
    go0 = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c == 0 || c == 6) go0 = 1'b0;
      if (c == 5) go0 = 1'b1;
      ev = (c >= 2) && (c <= 32) && (c % 2 == 0);
      if (out_valid0) strobes++;
      chk("b2b_valid", 32'(out_valid0), 32'(ev));
      if (ev) begin
        chk("b2b_addr", 32'(out_addr0), 32'((c - 2) / 2));
        chk("b2b_data", 32'(out_data0), 32'(((c - 2) / 2) % 4));
      end
      chk("b2b_done", 32'(done0), 32'(c == 32));
      if (c == 33) chk("b2b_busy_fall", 32'(busy0), 32'd0);
    end
    chk("b2b_strobes", 32'(strobes), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
